// File: rtl/ap_fifo_framer_pkg.sv
// Shared types and header layout for the ap_fifo_framer stream framer.
// The header is one 128-bit word placed ahead of each frame's payload.
package ap_fifo_framer_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FILL  = 2'd1,
        HDR   = 2'd2,
        DRAIN = 2'd3
    } state_t;

    localparam logic [15:0] HDR_MAGIC = 16'hF5A0;

    localparam int HDR_MAGIC_LSB = 112;
    localparam int HDR_MAGIC_W   = 16;
    localparam int HDR_CHID_LSB  = 104;
    localparam int HDR_CHID_W    = 8;
    localparam int HDR_FLAGS_LSB = 96;
    localparam int HDR_FLAGS_W   = 8;
    localparam int HDR_SEQ_LSB   = 64;
    localparam int HDR_SEQ_W     = 32;
    localparam int HDR_LEN_LSB   = 48;
    localparam int HDR_LEN_W     = 16;

    localparam int FLAG_TIMEOUT = 0;

    function automatic logic [127:0] build_header(
        input logic [HDR_CHID_W-1:0]  ch_id,
        input logic [HDR_FLAGS_W-1:0] flags,
        input logic [HDR_SEQ_W-1:0]   seq,
        input logic [HDR_LEN_W-1:0]   len
    );
        logic [127:0] w_hdr;
        w_hdr = '0;
        w_hdr[HDR_MAGIC_LSB +: HDR_MAGIC_W] = HDR_MAGIC;
        w_hdr[HDR_CHID_LSB  +: HDR_CHID_W]  = ch_id;
        w_hdr[HDR_FLAGS_LSB +: HDR_FLAGS_W] = flags;
        w_hdr[HDR_SEQ_LSB   +: HDR_SEQ_W]   = seq;
        w_hdr[HDR_LEN_LSB   +: HDR_LEN_W]   = len;
        return w_hdr;
    endfunction

endpackage

// File: rtl/framer_buf.sv
// Frame payload store: one write port, one read port, one-cycle registered read.
// Storage is not reset; only the framer's word count decides what is valid.
module framer_buf
    import ap_fifo_framer_pkg::*;
#(
    parameter int DATA_W = 128,
    parameter int DEPTH  = 64,
    parameter int AW     = 6
) (
    input  logic              clk,
    input  logic              i_wr_en,
    input  logic [AW-1:0]     i_wr_addr,
    input  logic [DATA_W-1:0] i_wr_data,
    input  logic              i_rd_en,
    input  logic [AW-1:0]     i_rd_addr,
    output logic [DATA_W-1:0] o_rd_data
);

    logic [DATA_W-1:0] r_mem [DEPTH];
    logic [DATA_W-1:0] r_rd_data;

    always_ff @(posedge clk) begin
        if (i_wr_en) begin
            r_mem[i_wr_addr] <= i_wr_data;
        end
        if (i_rd_en) begin
            r_rd_data <= r_mem[i_rd_addr];
        end
    end

    assign o_rd_data = r_rd_data;

endmodule

// File: rtl/ap_fifo_framer.sv
// Packs an ap_fifo word stream into header-prefixed frames, closing a frame
// when it is full or when input has been idle for TIMEOUT cycles.
module ap_fifo_framer
    import ap_fifo_framer_pkg::*;
#(
    parameter int          DATA_W    = 128,
    parameter int          MAX_WORDS = 64,
    parameter int          TIMEOUT   = 1024,
    parameter logic [7:0]  CH_ID     = 8'd0,
    parameter int          SEQ_W     = 32
) (
    input  logic              ap_clk,
    input  logic              ap_rst,
    input  logic [DATA_W-1:0] in_V_V_dout,
    input  logic              in_V_V_empty_n,
    output logic              in_V_V_read,
    output logic [DATA_W-1:0] out_V_V_din,
    input  logic              out_V_V_full_n,
    output logic              out_V_V_write,
    output logic [SEQ_W-1:0]  frames_sent,
    output logic              busy
);

    localparam int            AW        = (MAX_WORDS > 1) ? $clog2(MAX_WORDS) : 1;
    localparam int            IW        = $clog2(TIMEOUT + 1);
    localparam logic [15:0]   MAX_CNT   = 16'(MAX_WORDS);
    localparam logic [IW-1:0] IDLE_LAST = IW'(TIMEOUT - 1);

    state_t            r_state;
    logic [15:0]       r_count;
    logic [IW-1:0]     r_idle;
    logic [7:0]        r_flags;
    logic [SEQ_W-1:0]  r_frames;
    logic [AW-1:0]     r_rd_ptr;

    logic              w_read;
    logic              w_write;
    logic              w_last;
    logic              w_rd_en;
    logic [AW-1:0]     w_rd_addr;
    logic [DATA_W-1:0] w_buf_dout;
    logic [127:0]      w_header;

    assign w_read  = in_V_V_empty_n && (r_state == IDLE || r_state == FILL) && (r_count < MAX_CNT);
    assign w_write = (r_state == HDR || r_state == DRAIN) && out_V_V_full_n;
    assign w_last  = (16'(r_rd_ptr) == r_count - 16'd1);
    assign w_rd_en = (r_state == HDR || r_state == DRAIN);

    // Prefetch the next payload word on each accept so DRAIN runs at one word per cycle;
    // HDR keeps reading index 0, so word 0 is already waiting when DRAIN starts.
    assign w_rd_addr = (r_state == DRAIN && w_write && !w_last) ? r_rd_ptr + AW'(1) : r_rd_ptr;

    assign w_header = build_header(CH_ID, r_flags, 32'(r_frames), r_count);

    framer_buf #(
        .DATA_W (DATA_W),
        .DEPTH  (MAX_WORDS),
        .AW     (AW)
    ) u_buf (
        .clk       (ap_clk),
        .i_wr_en   (w_read),
        .i_wr_addr (r_count[AW-1:0]),
        .i_wr_data (in_V_V_dout),
        .i_rd_en   (w_rd_en),
        .i_rd_addr (w_rd_addr),
        .o_rd_data (w_buf_dout)
    );

    always_ff @(posedge ap_clk) begin
        if (ap_rst) begin
            r_state  <= IDLE;
            r_count  <= '0;
            r_idle   <= '0;
            r_flags  <= '0;
            r_frames <= '0;
            r_rd_ptr <= '0;
        end else begin
            unique case (r_state)
                IDLE: begin
                    if (w_read) begin
                        r_count <= r_count + 16'd1;
                        r_idle  <= '0;
                        r_state <= FILL;
                    end
                end
                FILL: begin
                    // A read in the would-be timeout cycle keeps the frame open.
                    if (r_count == MAX_CNT) begin
                        r_flags <= '0;
                        r_idle  <= '0;
                        r_state <= HDR;
                    end else if (w_read) begin
                        r_count <= r_count + 16'd1;
                        r_idle  <= '0;
                    end else if (r_idle == IDLE_LAST) begin
                        r_flags               <= '0;
                        r_flags[FLAG_TIMEOUT] <= 1'b1;
                        r_idle                <= '0;
                        r_state               <= HDR;
                    end else begin
                        r_idle <= r_idle + IW'(1);
                    end
                end
                HDR: begin
                    if (w_write) begin
                        r_frames <= r_frames + SEQ_W'(1);
                        r_state  <= DRAIN;
                    end
                end
                DRAIN: begin
                    if (w_write) begin
                        if (w_last) begin
                            r_count  <= '0;
                            r_rd_ptr <= '0;
                            r_state  <= IDLE;
                        end else begin
                            r_rd_ptr <= r_rd_ptr + AW'(1);
                        end
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    always_comb begin
        out_V_V_din = '0;
        if (r_state == HDR) begin
            out_V_V_din = w_header;
        end else if (r_state == DRAIN) begin
            out_V_V_din = w_buf_dout;
        end
    end

    assign in_V_V_read   = w_read;
    assign out_V_V_write = w_write;
    assign frames_sent   = r_frames;
    assign busy          = (r_state != IDLE);

endmodule

// File: tb/tb_ap_fifo_framer.sv
// Randomized self-checking bench for ap_fifo_framer: bursts of words are split
// into expected frames by a queue model and compared word-by-word at the output.
module tb_ap_fifo_framer;

    localparam int         MAXW  = 64;
    localparam int         TO    = 16;
    localparam int         SEQ_W = 4;
    localparam logic [7:0] CH    = 8'hA5;

    logic              ap_clk = 1'b0;
    logic              ap_rst = 1'b1;
    logic [127:0]      in_V_V_dout = '0;
    logic              in_V_V_empty_n = 1'b0;
    logic              in_V_V_read;
    logic [127:0]      out_V_V_din;
    logic              out_V_V_full_n = 1'b1;
    logic              out_V_V_write;
    logic [SEQ_W-1:0]  frames_sent;
    logic              busy;

    always #5 ap_clk = ~ap_clk;

    ap_fifo_framer #(
        .DATA_W    (128),
        .MAX_WORDS (MAXW),
        .TIMEOUT   (TO),
        .CH_ID     (CH),
        .SEQ_W     (SEQ_W)
    ) dut (
        .ap_clk         (ap_clk),
        .ap_rst         (ap_rst),
        .in_V_V_dout    (in_V_V_dout),
        .in_V_V_empty_n (in_V_V_empty_n),
        .in_V_V_read    (in_V_V_read),
        .out_V_V_din    (out_V_V_din),
        .out_V_V_full_n (out_V_V_full_n),
        .out_V_V_write  (out_V_V_write),
        .frames_sent    (frames_sent),
        .busy           (busy)
    );

    int n_checks = 0;
    int n_errors = 0;

    logic [127:0] in_q[$];
    logic [127:0] exp_q[$];
    int cyc = 0;
    int rd_cnt = 0;
    int pending = 0;
    int payload_seen = 0;
    int gap_run = 0;
    int gap_pct = 0;
    int full_mode = 0;
    int last_rd_cyc = 0;
    int hdr_cyc = 0;
    int seq_model = 0;
    bit mon_en = 1'b0;

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [127:0] model_hdr(input int seq, input int flags, input int len);
        return {16'hF5A0, CH, 8'(flags), 32'(seq), 16'(len), 48'h0};
    endfunction

    // Queue a burst and its expected frames: full chunks of MAXW close on size,
    // a short remainder closes on timeout.
    task automatic add_burst(input int n, input bit counting);
        logic [127:0] v[$];
        int len;
        for (int i = 0; i < n; i++) begin
            if (counting) v.push_back(128'(i));
            else v.push_back({$urandom(), $urandom(), $urandom(), $urandom()});
            in_q.push_back(v[i]);
        end
        for (int base = 0; base < n; base += MAXW) begin
            len = (n - base < MAXW) ? n - base : MAXW;
            exp_q.push_back(model_hdr(seq_model, (len < MAXW) ? 1 : 0, len));
            seq_model = (seq_model + 1) % (1 << SEQ_W);
            for (int k = 0; k < len; k++) exp_q.push_back(v[base + k]);
        end
    endtask

    task automatic cycle();
        logic [127:0] e;
        bit gap;
        gap = (gap_run < 2) && ($urandom_range(99) < gap_pct);
        if (in_q.size() > 0 && !gap) begin
            in_V_V_empty_n = 1'b1;
            in_V_V_dout    = in_q[0];
            gap_run        = 0;
        end else begin
            in_V_V_empty_n = 1'b0;
            in_V_V_dout    = '0;
            if (gap) gap_run++;
        end
        case (full_mode)
            0:       out_V_V_full_n = 1'b1;
            1:       out_V_V_full_n = ~out_V_V_full_n;
            default: out_V_V_full_n = 1'($urandom_range(1));
        endcase
        #1;
        if (mon_en) begin
            if (!out_V_V_full_n) check("wr_while_full", out_V_V_write, 0);
            if (pending > 0 || out_V_V_write) check("rd_while_output", in_V_V_read, 0);
            if (in_V_V_read) begin
                if (!in_V_V_empty_n) check("rd_without_data", in_V_V_read, 0);
                else void'(in_q.pop_front());
                rd_cnt++;
                last_rd_cyc = cyc;
            end
            if (out_V_V_write) begin
                if (exp_q.size() == 0) begin
                    check("extra_write", out_V_V_write, 0);
                end else begin
                    e = exp_q.pop_front();
                    if (pending == 0) begin
                        check("header", out_V_V_din, e);
                        pending = int'(e[63:48]);
                        hdr_cyc = cyc;
                        $display("frame seq=%0d len=%0d flags=%0d cyc=%0d",
                                 out_V_V_din[95:64], out_V_V_din[63:48], out_V_V_din[103:96], cyc);
                    end else begin
                        check("payload", out_V_V_din, e);
                        pending--;
                        payload_seen++;
                    end
                end
            end
        end
        @(posedge ap_clk);
        #1;
        cyc++;
    endtask

    task automatic drain_all(input string tag, input int budget);
        int n;
        n = 0;
        while ((in_q.size() > 0 || exp_q.size() > 0 || busy) && n < budget) begin
            cycle();
            n++;
        end
        check({tag, "_budget_expired"}, n >= budget, 0);
        repeat (TO + 4) cycle();
    endtask

    task automatic do_reset();
        mon_en = 1'b0;
        ap_rst = 1'b1;
        cycle();
        ap_rst = 1'b0;
        in_q.delete();
        exp_q.delete();
        pending   = 0;
        seq_model = 0;
        mon_en    = 1'b1;
    endtask

    initial begin
        int n;
        repeat (3) cycle();
        ap_rst = 1'b0;
        check("rst_write",  out_V_V_write, 0);
        check("rst_read",   in_V_V_read, 0);
        check("rst_busy",   busy, 0);
        check("rst_frames", frames_sent, 0);
        check("rst_din",    out_V_V_din, 0);
        mon_en = 1'b1;

        // 64 counting words, size close
        rd_cnt = 0;
        add_burst(64, 1'b1);
        drain_all("burst64", 1000);
        check("burst64_reads", rd_cnt, 64);

        // 5 words then idle: header presented on the edge completing TO idle cycles
        rd_cnt = 0;
        add_burst(5, 1'b0);
        drain_all("timeout5", 1000);
        check("timeout5_reads", rd_cnt, 5);
        check("timeout5_latency", hdr_cyc - last_rd_cyc, TO + 1);

        // backpressure toggling each cycle
        full_mode = 1;
        rd_cnt = 0;
        add_burst(64, 1'b1);
        drain_all("bp64", 2000);
        check("bp64_reads", rd_cnt, 64);
        full_mode = 0;

        // 130 continuous words from a fresh sequence
        do_reset();
        rd_cnt = 0;
        add_burst(130, 1'b0);
        drain_all("cont130", 2000);
        check("cont130_reads", rd_cnt, 130);
        check("cont130_frames_sent", frames_sent, 3);

        // reset in the middle of DRAIN
        payload_seen = 0;
        add_burst(64, 1'b0);
        n = 0;
        while (payload_seen < 10 && n < 500) begin
            cycle();
            n++;
        end
        check("mid_rst_budget_expired", n >= 500, 0);
        mon_en = 1'b0;
        ap_rst = 1'b1;
        cycle();
        ap_rst = 1'b0;
        check("mid_rst_write",  out_V_V_write, 0);
        check("mid_rst_read",   in_V_V_read, 0);
        check("mid_rst_busy",   busy, 0);
        check("mid_rst_frames", frames_sent, 0);
        check("mid_rst_din",    out_V_V_din, 0);
        in_q.delete();
        exp_q.delete();
        pending   = 0;
        seq_model = 0;
        mon_en    = 1'b1;
        add_burst(3, 1'b0);
        drain_all("post_rst3", 1000);
        check("post_rst_frames", frames_sent, 1);

        // 17 single-word frames: sequence wraps at 2^SEQ_W
        do_reset();
        for (int i = 0; i < 17; i++) begin
            add_burst(1, 1'b0);
            drain_all("single", 500);
        end
        check("wrap_frames_sent", frames_sent, 1);
        check("wrap_hdr_seq_zero", hdr_cyc > 0, 1);

        // random bursts with input gaps and random backpressure
        full_mode = 2;
        gap_pct   = 30;
        for (int b = 0; b < 5; b++) begin
            rd_cnt = 0;
            n = $urandom_range(150, 1);
            add_burst(n, 1'b0);
            drain_all("random", 4000);
            check("random_reads", rd_cnt, n);
            check("random_frames_sent", frames_sent, seq_model);
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
